bcd_conv_sched: RTL and testbench

Round-robin scheduler that shares one 6-bit binary-to-BCD converter between four requesters. It sits between the requesters, such as display-digit drivers or status formatters, and a single combinational converter instance. It latches the winning operand, enables the converter, waits a programmable settle time to cover the converter's propagation delay, then captures the BCD result. Each result goes back to its requester with a one-cycle acknowledge.

---
 rtl/bcd_conv_sched.sv | 133 +++++++++++++
 tb/tb_bcd_conv_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one 6-bit binary-to-BCD converter between four requesters.
// Optional macro BCD_SCHED_RANGE_CHECK_EN: operands above 39 are rejected at grant without using the converter.
module bcd_conv_sched #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [23:0] bin_bus,
  input  logic [5:0]  conv_bcd,
  output logic        conv_g_n,
  output logic [5:0]  conv_bin,
  output logic [3:0]  ack,
  output logic [5:0]  bcd_out,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, ACK} state_t;

  localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] LP_INVALID     = 6'h3F;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic [3:0]  r_cnt;
  logic        r_conv_g_n;
  logic [5:0]  r_conv_bin;
  logic [3:0]  r_ack;
  logic [5:0]  r_bcd_out;
  logic        r_err;

  logic        w_any;
  logic [1:0]  w_idx;
  logic [1:0]  w_grant_idx;
  logic [5:0]  w_operand;
  logic        w_out_of_range;

  // Scan from the farthest offset down so the nearest requester at or after r_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_any       = 1'b0;
    w_idx       = r_ptr;
    w_grant_idx = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) begin
        w_any       = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  assign w_operand = bin_bus[6*int'(w_grant_idx) +: 6];

`ifdef BCD_SCHED_RANGE_CHECK_EN
  assign w_out_of_range = (w_operand > 6'd39);
`else
  assign w_out_of_range = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = w_out_of_range ? ACK : SETTLE;
      SETTLE:  if (r_cnt == 4'd0) w_next = CAPTURE;
      CAPTURE: w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_ptr      <= 2'd0;
      r_grant    <= 2'd0;
      r_cnt      <= 4'd0;
      r_conv_g_n <= 1'b1;
      r_conv_bin <= 6'd0;
      r_ack      <= 4'b0000;
      r_bcd_out  <= LP_INVALID;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant    <= w_grant_idx;
            r_conv_bin <= w_operand;
            if (w_out_of_range) begin
              r_bcd_out <= LP_INVALID;
              r_err     <= 1'b1;
              r_ack     <= 4'b0001 << w_grant_idx;
            end else begin
              r_conv_g_n <= 1'b0;
              r_cnt      <= LP_SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        CAPTURE: begin
          r_bcd_out <= conv_bcd;
          r_err     <= (conv_bcd == LP_INVALID);
          r_ack     <= 4'b0001 << r_grant;
        end
        ACK: begin
          r_ack      <= 4'b0000;
          r_conv_g_n <= 1'b1;
          r_ptr      <= r_grant + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign conv_g_n = r_conv_g_n;
  assign conv_bin = r_conv_bin;
  assign ack      = r_ack;
  assign bcd_out  = r_bcd_out;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for bcd_conv_sched with a behavioural converter on the shared port.
// Honours BCD_SCHED_RANGE_CHECK_EN for the out-of-range expectations.
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] bin_bus;
  logic [5:0]  conv_bcd;
  logic        conv_g_n;
  logic [5:0]  conv_bin;
  logic [3:0]  ack;
  logic [5:0]  bcd_out;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bcd_conv_sched #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .bin_bus  (bin_bus),
    .conv_bcd (conv_bcd),
    .conv_g_n (conv_g_n),
    .conv_bin (conv_bin),
    .ack      (ack),
    .bcd_out  (bcd_out),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] conv_model(input logic [5:0] b);
    if (b > 6'd39) return 6'h3F;
    return {2'(b / 6'd10), 4'(b % 6'd10)};
  endfunction

  assign conv_bcd = conv_g_n ? 6'h3F : conv_model(conv_bin);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      if (ack != 4'b0000) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 12) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  logic [3:0] cont_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [5:0] cont_bcd [5] = '{6'h05, 6'h12, 6'h39, 6'h00, 6'h05};

  initial begin
    int   n;
    logic seen;

    rst_n   = 1'b0;
    req     = 4'b0000;
    bin_bus = 24'd0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset: {ack, conv_g_n, conv_bin, bcd_out, err, busy}.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("reset_idle", {ack, conv_g_n, conv_bin, bcd_out, err, busy},
            {4'b0000, 1'b1, 6'd0, 6'h3F, 1'b0, 1'b0});
    end

    // Single request from requester 2, operand 27.
    bin_bus[12 +: 6] = 6'd27;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("single_grant", {busy, conv_g_n, conv_bin}, {1'b1, 1'b0, 6'd27});
    tick();
    tick();
    check("single_no_early_ack", ack, 4'b0000);
    tick();
    check("single_ack", {ack, bcd_out, err}, {4'b0100, 6'b10_0111, 1'b0});
    tick();
    check("single_done", {busy, ack, conv_g_n}, {1'b0, 4'b0000, 1'b1});

    // Reset pulse returns the pointer to 0, then all four contend.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bin_bus = {6'd0, 6'd39, 6'd12, 6'd5};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack(20, n, seen);
      check("cont_ack_seen", {31'd0, seen}, 32'd1);
      check("cont_ack_order", ack, cont_ack[j]);
      check("cont_bcd", {err, bcd_out}, {1'b0, cont_bcd[j]});
      if (j > 0) check("cont_spacing", n, 5);
    end
    req = 4'b0000;
    wait_idle("cont_idle");

    // Out-of-range operand 45 on requester 1 (pointer now at 1).
    bin_bus[6 +: 6] = 6'd45;
    req = 4'b0010;
    tick();
    req = 4'b0000;
`ifdef BCD_SCHED_RANGE_CHECK_EN
    check("oor_fast_ack", {ack, bcd_out, err, conv_g_n}, {4'b0010, 6'h3F, 1'b1, 1'b1});
    tick();
    check("oor_fast_done", {busy, ack, conv_g_n}, {1'b0, 4'b0000, 1'b1});
`else
    check("oor_grant", {conv_g_n, conv_bin}, {1'b0, 6'd45});
    tick();
    tick();
    check("oor_no_early_ack", ack, 4'b0000);
    tick();
    check("oor_ack", {ack, bcd_out, err}, {4'b0010, 6'h3F, 1'b1});
    tick();
    check("oor_done", {busy, ack}, {1'b0, 4'b0000});
`endif

    // Operand change 13 -> 30 during SETTLE on requester 3.
    bin_bus[18 +: 6] = 6'd13;
    req = 4'b1000;
    tick();
    bin_bus[18 +: 6] = 6'd30;
    req = 4'b0000;
    check("chg_grant", conv_bin, 6'd13);
    tick();
    check("chg_settle", conv_bin, 6'd13);
    tick();
    check("chg_capture", {conv_g_n, conv_bin}, {1'b0, 6'd13});
    tick();
    check("chg_ack", {ack, bcd_out, err}, {4'b1000, 6'h13, 1'b0});
    tick();

    // Move the pointer to 2 with a conversion on requester 1 (operand 7).
    bin_bus[6 +: 6] = 6'd7;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    repeat (3) tick();
    check("pre_rst_ack", {ack, bcd_out}, {4'b0010, 6'h07});
    tick();

    // Reset during SETTLE of a requester-3 conversion.
    bin_bus[18 +: 6] = 6'd20;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    check("mid_settle", {ack, conv_g_n, busy}, {4'b0000, 1'b0, 1'b1});
    rst_n = 1'b0;
    tick();
    check("mid_reset", {ack, conv_g_n, busy, bcd_out, err},
          {4'b0000, 1'b1, 1'b0, 6'h3F, 1'b0});
    rst_n = 1'b1;
    req = 4'b1010;
    tick();
    req = 4'b0000;
    check("post_rst_grant", {conv_g_n, conv_bin}, {1'b0, 6'd7});
    wait_ack(10, n, seen);
    check("post_rst_ack_seen", {31'd0, seen}, 32'd1);
    check("post_rst_ack", {ack, bcd_out}, {4'b0010, 6'h07});
    wait_idle("post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
